// File: rtl/led_blink_scheduler.sv
// Round-robin scheduler that lends one board LED to N_REQ blink-pattern requesters.
// Optional macro HEARTBEAT_EN: 1 Hz heartbeat on the LED while idle.
module led_blink_scheduler #(
   parameter int CLK_HZ = 5_000_000,
   parameter int N_REQ  = 4,
   parameter int PAT_W  = 8,
   parameter int GAP_MS = 100
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*PAT_W-1:0] pattern,
   input  logic [N_REQ*16-1:0]    step_ms,
   input  logic [N_REQ*4-1:0]     reps,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic                   led
);

   localparam int TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
   localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_CYC  = (GAP_MS * TICK_DIV > 0) ? GAP_MS * TICK_DIV : 1;
   localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [15:0]       step_q, step_d;
   logic [3:0]        pass_q, pass_d;
   logic              cont_q, cont_d;
   logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
   logic [PS_W-1:0]   presc_q, presc_d;
   logic [15:0]       ms_q, ms_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [N_REQ-1:0]  done_q, done_d;

   logic              sel_found;
   logic [IDX_W-1:0]  sel_idx;
   logic [IDX_W-1:0]  cand;
   logic              tick, step_last, bit_end, replay;
   logic [N_REQ-1:0]  grant_vec;
   logic              idle_led;

   // First asserted request at or after rr_ptr, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign grant_vec = N_REQ'(1) << idx_q;
   assign tick      = (presc_q == PS_W'(TICK_DIV - 1));
   // A step of 0 ms is played as 1 ms.
   assign step_last = (step_q == 16'd0) ? (ms_q == 16'd0) : (ms_q == step_q - 16'd1);
   assign bit_end   = tick && step_last;
   assign replay    = cont_q ? req[idx_q] : (pass_q != 4'd1);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rr_ptr_d  = rr_ptr_q;
      pat_d     = pat_q;
      step_d    = step_q;
      pass_d    = pass_q;
      cont_d    = cont_q;
      bit_idx_d = bit_idx_q;
      presc_d   = presc_q;
      ms_d      = ms_q;
      gap_d     = gap_q;
      done_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               idx_d   = sel_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            pat_d     = pattern[idx_q*PAT_W +: PAT_W];
            step_d    = step_ms[idx_q*16 +: 16];
            pass_d    = reps[idx_q*4 +: 4];
            cont_d    = (reps[idx_q*4 +: 4] == 4'd0);
            rr_ptr_d  = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            bit_idx_d = BIT_W'(PAT_W - 1);
            presc_d   = '0;
            ms_d      = '0;
            state_d   = S_PLAY;
         end
         S_PLAY: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
               ms_d = step_last ? 16'd0 : ms_q + 16'd1;
            end
            if (bit_end) begin
               if (bit_idx_q != '0) begin
                  bit_idx_d = bit_idx_q - 1'b1;
               end else if (replay) begin
                  bit_idx_d = BIT_W'(PAT_W - 1);
                  if (!cont_q) pass_d = pass_q - 4'd1;
               end else begin
                  state_d = S_GAP;
                  done_d  = grant_vec;
                  gap_d   = '0;
                  presc_d = '0;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         rr_ptr_q  <= '0;
         pat_q     <= '0;
         step_q    <= '0;
         pass_q    <= '0;
         cont_q    <= 1'b0;
         bit_idx_q <= '0;
         presc_q   <= '0;
         ms_q      <= '0;
         gap_q     <= '0;
         done_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rr_ptr_q  <= rr_ptr_d;
         pat_q     <= pat_d;
         step_q    <= step_d;
         pass_q    <= pass_d;
         cont_q    <= cont_d;
         bit_idx_q <= bit_idx_d;
         presc_q   <= presc_d;
         ms_q      <= ms_d;
         gap_q     <= gap_d;
         done_q    <= done_d;
      end
   end

`ifdef HEARTBEAT_EN
   localparam int HB_HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
   localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

   logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
   logic            hb_phase_q, hb_phase_d;

   // Held at zero outside IDLE so every IDLE entry restarts with the LED off.
   always_comb begin
      hb_cnt_d   = '0;
      hb_phase_d = 1'b0;
      if (state_q == S_IDLE) begin
         if (hb_cnt_q == HB_W'(HB_HALF - 1)) begin
            hb_cnt_d   = '0;
            hb_phase_d = ~hb_phase_q;
         end else begin
            hb_cnt_d   = hb_cnt_q + 1'b1;
            hb_phase_d = hb_phase_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hb_cnt_q   <= '0;
         hb_phase_q <= 1'b0;
      end else begin
         hb_cnt_q   <= hb_cnt_d;
         hb_phase_q <= hb_phase_d;
      end
   end

   assign idle_led = hb_phase_q;
`else
   assign idle_led = 1'b0;
`endif

   assign grant = (state_q == S_LOAD || state_q == S_PLAY) ? grant_vec : '0;
   assign done  = done_q;
   assign busy  = (state_q != S_IDLE);
   assign led   = (state_q == S_PLAY) ? pat_q[bit_idx_q] :
                  (state_q == S_IDLE) ? idle_led : 1'b0;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler: single play, round-robin, continuous mode,
// mid-play reset and idle LED behaviour (heartbeat checked when HEARTBEAT_EN is defined).
module tb_led_blink_scheduler;

   localparam int CLK_HZ  = 10_000;
   localparam int N_REQ   = 4;
   localparam int PAT_W   = 8;
   localparam int GAP_MS  = 2;
   localparam int BIT_CYC = 10;
   localparam int GAP_LEN = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] pattern = '0;
   logic [63:0] step_ms = '0;
   logic [15:0] reps = '0;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic        led;

   int n_checks = 0;
   int n_fail   = 0;

   led_blink_scheduler #(
      .CLK_HZ (CLK_HZ),
      .N_REQ  (N_REQ),
      .PAT_W  (PAT_W),
      .GAP_MS (GAP_MS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .pattern (pattern),
      .step_ms (step_ms),
      .reps    (reps),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .led     (led)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int i, input logic [7:0] pat, input logic [15:0] stp,
                          input logic [3:0] rp);
      pattern[i*8 +: 8]  = pat;
      step_ms[i*16 +: 16] = stp;
      reps[i*4 +: 4]     = rp;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      step_clk();
      step_clk();
      rst_n = 1'b1;
   endtask

   // Counts GAP cycles starting at the current (first GAP) sample.
   task automatic gap_check();
      int n = 0;
      int led_hi = 0;
      int extra_done = 0;
      while (busy && grant == '0 && n < 1000) begin
         n++;
         if (led) led_hi++;
         if (n > 1 && done != '0) extra_done++;
         step_clk();
      end
      check_eq("gap_len", n, GAP_LEN);
      check_eq("gap_led_on_cycles", led_hi, 0);
      check_eq("done_pulse_width", extra_done, 0);
   endtask

   // Called in the LOAD cycle; checks every PLAY cycle, then the done pulse.
   task automatic play_check(input int idx, input logic [7:0] pat, input int cpb,
                             input int total, input int drop_at);
      logic [3:0] oh;
      oh = 4'(1 << idx);
      for (int c = 0; c < total; c++) begin
         if (c == drop_at) req[idx] = 1'b0;
         step_clk();
         check_eq("play_led", led, pat[7 - ((c / cpb) % 8)]);
         check_eq("play_grant", grant, oh);
         check_eq("play_done", done, 4'b0000);
      end
      step_clk();
      check_eq("end_done", done, oh);
      check_eq("end_grant", grant, 4'b0000);
      check_eq("end_led", led, 1'b0);
      check_eq("end_busy", busy, 1'b1);
      $display("play idx %0d pattern 0x%0h: %0d cycles checked", idx, pat, total);
   endtask

   task automatic run_grant(input int exp_idx, input int play_cycles, input logic [3:0] req_after);
      int w = 0;
      int n = 0;
      logic [3:0] oh;
      oh = 4'(1 << exp_idx);
      while (grant == '0 && w < 200) begin
         step_clk();
         w++;
      end
      check_eq("grant_order", grant, oh);
      req = req_after;
      while (grant != '0 && n < 5000) begin
         n++;
         step_clk();
      end
      check_eq("grant_len", n, play_cycles + 1);
      check_eq("grant_done", done, oh);
      $display("grant idx %0d held %0d cycles", exp_idx, n);
      gap_check();
   endtask

   initial begin
      int cps[6];
      int hb_err;
      logic exp_led;

      // 1: single play of 0xA5 on requester 1
      set_cfg(1, 8'hA5, 16'd1, 4'd1);
      do_reset();
      check_eq("rst_grant", grant, 4'b0000);
      check_eq("rst_done", done, 4'b0000);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_led", led, 1'b0);
      req = 4'b0010;
      step_clk();
      check_eq("t1_load_grant", grant, 4'b0010);
      check_eq("t1_load_busy", busy, 1'b1);
      check_eq("t1_load_led", led, 1'b0);
      play_check(1, 8'hA5, BIT_CYC, 8 * BIT_CYC, 0);
      gap_check();
      check_eq("t1_idle_busy", busy, 1'b0);

      // 2: all four requesting, round-robin order 0,1,2,3,0
      do_reset();
      set_cfg(0, 8'h81, 16'd1, 4'd1);
      set_cfg(2, 8'h0F, 16'd1, 4'd1);
      set_cfg(3, 8'hF0, 16'd2, 4'd1);
      req = 4'b1111;
      run_grant(0, 80, 4'b1111);
      run_grant(1, 80, 4'b1111);
      run_grant(2, 80, 4'b1111);
      run_grant(3, 160, 4'b1111);
      run_grant(0, 80, 4'b0000);

      // 3: continuous mode, step 0 treated as 1 ms, req dropped in second pass
      set_cfg(2, 8'h3C, 16'd0, 4'd0);
      req = 4'b0100;
      step_clk();
      check_eq("t3_load_grant", grant, 4'b0100);
      play_check(2, 8'h3C, BIT_CYC, 16 * BIT_CYC, 117);
      gap_check();

      // 4: reset mid-play, pointer returns to 0
      set_cfg(2, 8'hFF, 16'd1, 4'd1);
      req = 4'b0100;
      step_clk();
      check_eq("t4_load_grant", grant, 4'b0100);
      req = 4'b0000;
      repeat (30) step_clk();
      check_eq("t4_mid_led", led, 1'b1);
      rst_n = 1'b0;
      step_clk();
      check_eq("t4_rst_led", led, 1'b0);
      check_eq("t4_rst_grant", grant, 4'b0000);
      check_eq("t4_rst_busy", busy, 1'b0);
      check_eq("t4_rst_done", done, 4'b0000);
      rst_n = 1'b1;
      req = 4'b1001;
      run_grant(0, 80, 4'b0000);

      // 5: idle LED behaviour, then a request interrupts it
      do_reset();
      cps = '{0, 4999, 5000, 9999, 10000, 15000};
      hb_err = 0;
      for (int k = 0; k <= 17500; k++) begin
`ifdef HEARTBEAT_EN
         exp_led = ((k / 5000) % 2) == 1;
`else
         exp_led = 1'b0;
`endif
         if (k == cps[0] || k == cps[1] || k == cps[2] || k == cps[3] ||
             k == cps[4] || k == cps[5]) begin
            check_eq($sformatf("idle_led_k%0d", k), led, exp_led);
         end else if (led !== exp_led) begin
            hb_err++;
         end
         if (k < 17500) step_clk();
      end
      check_eq("idle_led_errors", hb_err, 0);
      req = 4'b1000;
      step_clk();
      check_eq("t5_load_grant", grant, 4'b1000);
      check_eq("t5_load_led", led, 1'b0);
      check_eq("t5_load_busy", busy, 1'b1);
      req = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
